fpu_denorm_rshift: RTL
======================

Name: fpu_denorm_rshift

Overview:
- Iterative right-shift denormalizer for FPU results that underflow: takes a normalized fraction (explicit leading one) and an underflow shift count.
- Produces the denormalized fraction plus guard/round/sticky bits for the rounding stage.
- Inverse of the denorm-detect path: it creates the leading zeros that the operand-side detection logic consumes.
- Sits between the FPU result normalizer and the rounder, with valid/ready handshakes on both sides.

Parameters:
FRAC_W, 64, fraction width in bits, including the explicit leading one
SHIFT_STEP, 8, maximum right-shift distance per SHIFT cycle
CNT_W, 7, shift-count width; must satisfy 2^CNT_W > FRAC_W+2

Ports:
rclk  input  1  clock; all state updates on the rising edge
arst  input  1  asynchronous active-high reset
in_vld  input  1  input request valid
in_rdy  output  1  block can accept a request (high only in IDLE)
in_frac  input  FRAC_W  fraction to denormalize
in_shcnt  input  CNT_W  right-shift amount
out_vld  output  1  result valid
out_rdy  input  1  downstream accepts result
out_frac  output  FRAC_W  denormalized fraction
out_guard  output  1  first bit shifted out below the LSB
out_round  output  1  second bit shifted out below the LSB
out_sticky  output  1  OR of all bits shifted out beyond the round bit
out_nz  output  1  OR of {out_frac, out_guard, out_round, out_sticky}

Behaviour:
- Reset (arst high, asynchronous):
  - state=IDLE, out_vld=0, in_rdy=1.
  - out_frac, out_guard, out_round and out_sticky are 0; out_nz is therefore 0.
  - in_vld is ignored while arst is high.
- Internal datapath: shift register {frac[FRAC_W-1:0], g, r} plus a separate sticky flop; remaining-count register rem[CNT_W-1:0].
- Clamp on accept: rem = min(in_shcnt, FRAC_W+2). For a count of FRAC_W+2 or more, the result is frac=0, g=0, r=0, sticky=|in_frac.
- States:
  - IDLE: in_rdy=1. On in_vld: load frac=in_frac, g=r=sticky=0, rem=clamped count. Go to DONE if the clamped count is 0, else SHIFT.
  - SHIFT: in_rdy=0. Each cycle, n=min(rem, SHIFT_STEP). Shift {frac,g,r} right by n with zero fill. sticky |= OR of the bits leaving r (including the old r and g when n is large enough). rem -= n. Go to DONE when rem-n==0.
  - DONE: out_vld=1. Outputs are held stable while out_rdy=0. On out_rdy go to IDLE; out_vld deasserts the next cycle.
- Latency: acceptance edge = cycle 0. out_vld rises at cycle ceil(clamped/SHIFT_STEP)+1. The minimum is 1 cycle, for count 0.
- No back-to-back accept in the cycle a result is consumed: IDLE is entered first, so throughput is one operation per latency+1 cycles.
- Output registers are driven from the datapath registers and are valid only while out_vld=1.
- arst asserted mid-SHIFT or mid-DONE: the in-flight operation is discarded, out_vld drops immediately (asynchronously), and the block returns to IDLE.

Optional Feature:
FPU_DENORM_RSHIFT_FAST_EN
- Defined: a full single-cycle barrel shifter is used. IDLE goes directly to DONE on accept for any count, so latency is always 1 cycle. The SHIFT state is unused.
- Not defined: the iterative SHIFT_STEP behaviour above.
- Results (frac, g, r, sticky, nz) are bit-identical in both builds; only latency differs.

Test Plan:
1. in_frac=0x8000_0000_0000_0000, in_shcnt=0 -> out_vld at cycle 1; out_frac=0x8000_0000_0000_0000; g=r=s=0; out_nz=1.
2. in_frac=0x8000_0000_0000_0001, in_shcnt=1 -> out_vld at cycle 2; out_frac=0x4000_0000_0000_0000; g=1, r=0, s=0.
3. in_frac=0xFFFF_FFFF_FFFF_FFFF, in_shcnt=20 -> 3 SHIFT cycles, out_vld at cycle 4; out_frac=0x0000_0FFF_FFFF_FFFF; g=1, r=1, s=1.
4. in_frac=0x1, in_shcnt=100 -> count clamped to 66, 9 SHIFT cycles, out_vld at cycle 10; out_frac=0; g=0, r=0, s=1; out_nz=1. With FPU_DENORM_RSHIFT_FAST_EN: same values at cycle 1.
5. Result in DONE, out_rdy held low 5 cycles with in_vld=1 -> outputs stable, in_rdy=0, no new accept. out_rdy=1 -> out_vld=0 and in_rdy=1 the next cycle.
6. arst pulsed during SHIFT of case 3 -> out_vld=0 and out_* cleared immediately; after release, case 2 stimulus gives the case-2 result with the case-2 latency.

Source files
------------

// File: rtl/fpu_denorm_rshift.sv
// Iterative right-shift denormalizer producing fraction plus guard/round/sticky.
// Define FPU_DENORM_RSHIFT_FAST_EN for a single-cycle barrel-shift build.
module fpu_denorm_rshift #(
    parameter int FRAC_W     = 64,
    parameter int SHIFT_STEP = 8,
    parameter int CNT_W      = 7
) (
    input  logic              rclk,
    input  logic              arst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [CNT_W-1:0]  in_shcnt,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_guard,
    output logic              out_round,
    output logic              out_sticky,
    output logic              out_nz
);

    localparam int SH_W = FRAC_W + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(SH_W);

    logic [1:0]       r_state;
    logic [SH_W-1:0]  r_sh;
    logic             r_sticky;
    logic [CNT_W-1:0] w_clamp;
    logic [SH_W-1:0]  w_load;

    assign w_load  = {in_frac, 2'b00};
    assign w_clamp = (in_shcnt > MAX_CNT) ? MAX_CNT : in_shcnt;

`ifdef FPU_DENORM_RSHIFT_FAST_EN
    logic [SH_W-1:0] w_fast_sh;
    logic            w_fast_st;

    // Everything shifted past the round position folds into sticky.
    assign w_fast_sh = w_load >> w_clamp;
    assign w_fast_st = |(w_load & ~({SH_W{1'b1}} << w_clamp));
`else
    localparam int STEP_W = $clog2(SHIFT_STEP + 1);
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

    logic [CNT_W-1:0]  r_rem;
    logic [STEP_W-1:0] w_n;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic [SH_W-1:0]   w_step_sh;
    logic              w_step_st;

    assign w_n       = (r_rem > STEP) ? STEP_W'(SHIFT_STEP)
                                      : r_rem[STEP_W-1:0];
    assign w_rem_nxt = r_rem - {{(CNT_W-STEP_W){1'b0}}, w_n};
    assign w_step_sh = r_sh >> w_n;
    assign w_step_st = |(r_sh & ~({SH_W{1'b1}} << w_n));
`endif

    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_sticky <= 1'b0;
`ifndef FPU_DENORM_RSHIFT_FAST_EN
            r_rem    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_vld) begin
`ifdef FPU_DENORM_RSHIFT_FAST_EN
                        r_sh     <= w_fast_sh;
                        r_sticky <= w_fast_st;
                        r_state  <= DONE;
`else
                        r_sh     <= w_load;
                        r_sticky <= 1'b0;
                        r_rem    <= w_clamp;
                        r_state  <= (w_clamp == '0) ? DONE : SHIFT;
`endif
                    end
                end
`ifndef FPU_DENORM_RSHIFT_FAST_EN
                SHIFT: begin
                    r_sh     <= w_step_sh;
                    r_sticky <= r_sticky | w_step_st;
                    r_rem    <= w_rem_nxt;
                    if (w_rem_nxt == '0)
                        r_state <= DONE;
                end
`endif
                DONE: begin
                    if (out_rdy)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_rdy     = (r_state == IDLE);
    assign out_vld    = (r_state == DONE);
    assign out_frac   = r_sh[SH_W-1:2];
    assign out_guard  = r_sh[1];
    assign out_round  = r_sh[0];
    assign out_sticky = r_sticky;
    assign out_nz     = (|r_sh) | r_sticky;

endmodule
